alu_display_scanner: RTL and testbench

//  Upstream of the per-digit hex seven-segment decoder. Captures an ALU result

---
 rtl/alu_display_scanner.sv | 146 ++++++++++++++
 tb/tb_alu_display_scanner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_display_scanner.sv
// rtl/alu_display_scanner.sv - holds an ALU result and scans its nibbles onto a hex seven-segment decoder
// Optional feature: LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module alu_display_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  in_overflow,
    output logic [3:0]            seg_value,
    output logic                  seg_overflow,
    output logic [DIGITS-1:0]     digit_en_n
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_SHOW    = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       scan_cnt_q, scan_cnt_d;
    logic [DW-1:0]       digit_q, digit_d;
    logic [4*DIGITS-1:0] held_data_q, held_data_d;
    logic                held_ovf_q, held_ovf_d;
    logic [4*DIGITS-1:0] staged_data_q, staged_data_d;
    logic                staged_ovf_q, staged_ovf_d;

    logic slot_wrap;
    logic frame_end;
    logic transfer;
    logic digit_blank;

    assign in_ready  = (state_q != ST_PENDING);
    assign transfer  = in_valid && in_ready;
    assign slot_wrap = (scan_cnt_q == CNT_LAST);
    assign frame_end = slot_wrap && (digit_q == DIG_LAST);

    always_comb begin
        scan_cnt_d = slot_wrap ? '0 : scan_cnt_q + 1'b1;
        digit_d    = digit_q;
        if (slot_wrap) begin
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
        end
    end

    // Staged data only reaches the held regs on a frame boundary, never mid-frame.
    always_comb begin
        state_d       = state_q;
        held_data_d   = held_data_q;
        held_ovf_d    = held_ovf_q;
        staged_data_d = staged_data_q;
        staged_ovf_d  = staged_ovf_q;
        case (state_q)
            ST_EMPTY: begin
                if (transfer) begin
                    held_data_d = in_data;
                    held_ovf_d  = in_overflow;
                    state_d     = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (transfer) begin
                    staged_data_d = in_data;
                    staged_ovf_d  = in_overflow;
                    state_d       = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_end) begin
                    held_data_d = staged_data_q;
                    held_ovf_d  = staged_ovf_q;
                    state_d     = ST_SHOW;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            scan_cnt_q    <= '0;
            digit_q       <= '0;
            held_data_q   <= '0;
            held_ovf_q    <= 1'b0;
            staged_data_q <= '0;
            staged_ovf_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            scan_cnt_q    <= scan_cnt_d;
            digit_q       <= digit_d;
            held_data_q   <= held_data_d;
            held_ovf_q    <= held_ovf_d;
            staged_data_q <= staged_data_d;
            staged_ovf_q  <= staged_ovf_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top nibble; a digit is blank while everything above and at it is zero.
    always_comb begin
        logic zero_run;
        zero_run    = 1'b1;
        digit_blank = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (held_data_q[4*k +: 4] == 4'd0);
            if ((digit_q == DW'(k)) && zero_run) begin
                digit_blank = 1'b1;
            end
        end
    end
`else
    assign digit_blank = 1'b0;
`endif

    always_comb begin
        seg_value = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digit_q == DW'(k)) begin
                seg_value = held_data_q[4*k +: 4];
            end
        end
    end

    assign seg_overflow = held_ovf_q && (digit_q == '0);

    // The first cycle of every slot stays dark so the previous digit does not ghost.
    always_comb begin
        digit_en_n = '1;
        if ((state_q != ST_EMPTY) && (scan_cnt_q != '0) && !digit_blank) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (digit_q == DW'(k)) begin
                    digit_en_n[k] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_display_scanner.sv
// tb/tb_alu_display_scanner.sv - scoreboard bench for alu_display_scanner (SCAN_DIV=4, DIGITS=2)
module tb_alu_display_scanner;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_overflow;
    logic [3:0] seg_value;
    logic       seg_overflow;
    logic [1:0] digit_en_n;

    alu_display_scanner #(.SCAN_DIV(4), .DIGITS(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_overflow  (in_overflow),
        .seg_value    (seg_value),
        .seg_overflow (seg_overflow),
        .digit_en_n   (digit_en_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  en;
        logic [3:0]  val;
        logic        dp;
        logic        rdy;
        logic [63:0] tag;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_checks;
    int   n_errors;

    // Rising edges since the last reset release; matches the DUT slot position.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input logic [63:0] tag, input int c,
                         input logic [1:0] en, input logic [3:0] val,
                         input logic dp, input logic rdy);
        n_checks++;
        if (digit_en_n !== en || seg_value !== val || seg_overflow !== dp || in_ready !== rdy) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got en=%b val=%h dp=%b rdy=%b, expected en=%b val=%h dp=%b rdy=%b",
                     tag, c, digit_en_n, seg_value, seg_overflow, in_ready, en, val, dp, rdy);
        end
    endtask

    task automatic push(input int c, input logic [1:0] en, input logic [3:0] val,
                        input logic dp, input logic rdy, input logic [63:0] tag);
        exp_t e;
        e.cyc = c; e.en = en; e.val = val; e.dp = dp; e.rdy = rdy; e.tag = tag;
        q.push_back(e);
    endtask

    // Monitor: compares the DUT on the falling edge of every cycle that has an expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL %s missed: expected cycle %0d, now cycle %0d", e.tag, e.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check(e.tag, e.cyc, e.en, e.val, e.dp, e.rdy);
            end
        end
    end

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic o);
        in_valid    = v;
        in_data     = d;
        in_overflow = o;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Empty after reset
        push(1,  2'b11, 4'h0, 1'b0, 1'b1, "empty");
        push(2,  2'b11, 4'h0, 1'b0, 1'b1, "empty");
        push(5,  2'b11, 4'h0, 1'b0, 1'b1, "empty");
        push(7,  2'b11, 4'h0, 1'b0, 1'b1, "empty");
        push(8,  2'b11, 4'h0, 1'b0, 1'b1, "empty");
        // A5 with overflow loaded from EMPTY
        push(9,  2'b10, 4'h5, 1'b1, 1'b1, "a5_d0");
        push(11, 2'b10, 4'h5, 1'b1, 1'b1, "a5_d0");
        push(12, 2'b11, 4'hA, 1'b0, 1'b1, "a5_blk1");
        push(13, 2'b01, 4'hA, 1'b0, 1'b1, "a5_d1");
        push(15, 2'b01, 4'hA, 1'b0, 1'b1, "a5_d1");
        push(16, 2'b11, 4'h5, 1'b1, 1'b1, "a5_blk0");
        // 12 staged while A5 still shown, swapped at boundary
        push(18, 2'b10, 4'h5, 1'b1, 1'b0, "pend12");
        push(23, 2'b01, 4'hA, 1'b0, 1'b0, "pend12");
        push(24, 2'b11, 4'h2, 1'b0, 1'b1, "show12");
        push(25, 2'b10, 4'h2, 1'b0, 1'b1, "show12");
        // 34 pushed mid digit1, FF held on in_valid during PENDING
        push(30, 2'b01, 4'h1, 1'b0, 1'b0, "pend34");
        push(31, 2'b01, 4'h1, 1'b0, 1'b0, "pend34");
        push(32, 2'b11, 4'h4, 1'b0, 1'b1, "show34");
        push(33, 2'b10, 4'h4, 1'b0, 1'b0, "ff_acc");
        push(36, 2'b11, 4'h3, 1'b0, 1'b0, "show34");
        push(37, 2'b01, 4'h3, 1'b0, 1'b0, "show34");
        push(40, 2'b11, 4'hF, 1'b1, 1'b1, "showff");
        push(41, 2'b10, 4'hF, 1'b1, 1'b1, "showff");
        push(42, 2'b10, 4'hF, 1'b1, 1'b0, "pend5a");

        wait_cyc(8);  drive(1'b1, 8'hA5, 1'b1);
        wait_cyc(9);  drive(1'b0, 8'h00, 1'b0);
        wait_cyc(17); drive(1'b1, 8'h12, 1'b0);
        wait_cyc(18); drive(1'b0, 8'h00, 1'b0);
        wait_cyc(29); drive(1'b1, 8'h34, 1'b0);
        wait_cyc(30); drive(1'b1, 8'hFF, 1'b1);
        wait_cyc(33); drive(1'b0, 8'h00, 1'b0);
        wait_cyc(41); drive(1'b1, 8'h5A, 1'b0);
        wait_cyc(42); drive(1'b0, 8'h00, 1'b0);
        wait_cyc(45);
        drain();

        // Asynchronous reset while PENDING
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", cyc, 2'b11, 4'h0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        push(1,  2'b11, 4'h0, 1'b0, 1'b1, "rst_emp");
        push(3,  2'b11, 4'h0, 1'b0, 1'b1, "rst_emp");
        push(9,  2'b11, 4'h0, 1'b0, 1'b1, "staglost");
        push(10, 2'b11, 4'h0, 1'b0, 1'b1, "staglost");
        push(13, 2'b11, 4'h0, 1'b0, 1'b1, "staglost");
        // 07: leading zero digit
        push(17, 2'b10, 4'h7, 1'b0, 1'b1, "z07_d0");
        push(20, 2'b11, 4'h0, 1'b0, 1'b1, "z07_blk1");
`ifdef LEADING_ZERO_BLANK_EN
        push(21, 2'b11, 4'h0, 1'b0, 1'b1, "z07_d1");
`else
        push(21, 2'b01, 4'h0, 1'b0, 1'b1, "z07_d1");
`endif
        push(24, 2'b11, 4'h7, 1'b0, 1'b1, "z07_blk0");
        push(25, 2'b10, 4'h7, 1'b0, 1'b1, "z07_d0");

        wait_cyc(16); drive(1'b1, 8'h07, 1'b0);
        wait_cyc(17); drive(1'b0, 8'h00, 1'b0);
        wait_cyc(26);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
